// File: rtl/mem_defs.sv
// Shared definitions for the memory responder and its CPU-side initiator:
// FSM state encodings, byte-enable width and the address legality check.
package mem_defs;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BE_WIDTH   = 4;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } req_t;

    // A request is illegal when misaligned or past the last storage word.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] addr, input int depth_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_WIDTH-1:2]} >= 32'(depth_words));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: byte-enabled synchronous write and registered read.
// The read register only updates on a read access, so it holds its value otherwise.
module mem_array
    import mem_defs::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [ADDR_BITS-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // NOTE: storage has no reset so it maps onto RAM macros; contents survive reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request in IDLE, waits
// WAIT_CYCLES, performs the storage access on RESP entry and holds the response.
module mem_responder
    import mem_defs::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    req_t                   req_q, req_d;
    logic                   err_q, err_d;
    logic                   load_q, load_d;

    req_t                   cur_req;
    logic                   cur_err;
    logic                   enter_resp;
    logic                   mem_en;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    // In IDLE the request comes straight from the ports, so a zero-wait
    // request can hit storage on its acceptance edge.
    always_comb begin
        if (state_q == IDLE) begin
            cur_req.write = req_write;
            cur_req.addr  = req_addr;
            cur_req.wdata = req_wdata;
            cur_req.be    = req_be;
        end else begin
            cur_req = req_q;
        end
        cur_err = addr_err(cur_req.addr, DEPTH_WORDS);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        err_d      = err_q;
        load_d     = load_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !reset) begin
                    req_d = cur_req;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_WIDTH'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    cnt_d      = '0;
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d  = cur_err;
            load_d = !cur_req.write;
        end
    end

    // NOTE: synchronous reset inside the clocked block; state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // Errored requests never touch storage; reset on the entry edge abandons the access.
    assign mem_en = enter_resp && !cur_err && !reset;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_mem_array (
        .clk_i   (clk),
        .en_i    (mem_en),
        .we_i    (cur_req.write),
        .be_i    (cur_req.be),
        .addr_i  (cur_req.addr[2 +: ADDR_BITS]),
        .wdata_i (cur_req.wdata),
        .rdata_o (mem_rdata)
    );

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = (state_q == RESP) && !reset;
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q && !err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_mem_responder;

    localparam int TB_DEPTH = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b1;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_be = '0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    exp_t        exp_q[$];
    exp_t        exp0_q[$];
    logic [31:0] model [2*TB_DEPTH];

    mem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DEPTH_WORDS(TB_DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the main instance: every completed response pops one expectation.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL resp_unexpected: got rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    fails++;
                    $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                             resp_rdata, resp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic push_exp(input bit which, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   idx;
        e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'(TB_DEPTH));
        e.rdata = '0;
        if (!e.err) begin
            idx = int'(a[9:2]) + (which ? TB_DEPTH : 0);
            if (w) begin
                for (int i = 0; i < 4; i++) if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = model[idx];
            end
        end
        if (which) exp0_q.push_back(e);
        else exp_q.push_back(e);
    endtask

    task automatic wait_resp(output int k, output bit ok);
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 30) begin
            @(negedge clk);
            k++;
            if (resp_valid) ok = 1'b1;
        end
    endtask

    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int exp_lat, input string name);
        int k;
        bit ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_accept: got req_ready=0 for 30 cycles, required acceptance", name);
            req_valid = 1'b0;
            return;
        end
        push_exp(1'b0, w, a, wd, be);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(k, ok);
        if (exp_lat >= 0) begin
            tests++;
            if (!ok || k != exp_lat) begin
                fails++;
                $display("FAIL %s_latency: got %0d cycles (seen=%0b), required %0d", name, k, ok, exp_lat);
            end
        end else if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_resp_timeout: got no resp_valid, required a response", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, b_req_ready, b_resp_valid} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h b_rdy=%b b_vld=%b, required all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, b_req_ready, b_resp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b/%b, required 1/1", req_ready, b_req_ready);
        end
    endtask

    task automatic test_load_after_store();
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, "las_store");
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 3, "las_load");
    endtask

    task automatic test_partial_store();
        do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, -1, "ps_init");
        do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, -1, "ps_be5");
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, -1, "ps_load");
        do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, -1, "ps_be0");
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, -1, "ps_load_be0");
        do_txn(1'b1, 32'h20, 32'h99887766, 4'hA, -1, "ps_beA");
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, -1, "ps_load_beA");
    endtask

    task automatic test_errors();
        do_txn(1'b1, 32'h13, 32'h0BADF00D, 4'hF, -1, "err_misaligned_store");
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, -1, "err_unchanged_load");
        do_txn(1'b0, 32'h12, 32'h0, 4'hF, -1, "err_misaligned_load");
        do_txn(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, -1, "err_word0_store");
        do_txn(1'b1, 32'(4*TB_DEPTH), 32'h12345678, 4'hF, -1, "err_oor_store");
        do_txn(1'b0, 32'(4*TB_DEPTH), 32'h0, 4'hF, -1, "err_oor_load");
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, -1, "err_word0_load");
        do_txn(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, -1, "err_high_load");
        do_txn(1'b1, 32'(4*TB_DEPTH-4), 32'h76543210, 4'hF, -1, "err_last_store");
        do_txn(1'b0, 32'(4*TB_DEPTH-4), 32'h0, 4'hF, -1, "err_last_load");
    endtask

    task automatic test_backpressure();
        int  k;
        bit  ok;
        int  done_cyc;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_accept: got req_ready=%b, required 1", req_ready);
        end
        push_exp(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1;
        req_addr = 32'h20;
        wait_resp(k, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_resp_timeout: got no resp_valid, required a response");
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || exp_q.size() == 0 ||
                resp_rdata !== exp_q[0].rdata || resp_err !== exp_q[0].err) begin
                fails++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b rdata=%h err=%b, required vld=1 rdy=0 stable data",
                         n, resp_valid, req_ready, resp_rdata, resp_err);
            end
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        done_cyc = cyc;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_same_cycle_accept: got req_ready=%b, required 0", req_ready);
        end
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        tests++;
        if (!ok || cyc != done_cyc + 1) begin
            fails++;
            $display("FAIL bp_held_accept: got acceptance %0d cycles after completion (seen=%0b), required 1",
                     cyc - done_cyc, ok);
        end
        push_exp(1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(k, ok);
        tests++;
        if (!ok || k != 3) begin
            fails++;
            $display("FAIL bp_held_latency: got %0d (seen=%0b), required 3", k, ok);
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_txn(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, -1, "rw_prior");
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
        ok = 1'b0;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rw_accept: got req_ready=0, required acceptance");
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            tests++;
            if ({req_ready, resp_valid, resp_err, resp_rdata} !== '0) begin
                fails++;
                $display("FAIL rw_reset_outputs_%0d: got rdy=%b vld=%b err=%b rdata=%h, required all 0",
                         n, req_ready, resp_valid, resp_err, resp_rdata);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL rw_after_reset_%0d: got vld=%b rdy=%b, required vld=0 rdy=1", n, resp_valid, req_ready);
            end
        end
        do_txn(1'b0, 32'h30, 32'h0, 4'hF, 3, "rw_load_prior");
    endtask

    task automatic test_back_to_back();
        logic        w_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] a_t  [6] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h40, 32'h40};
        logic [31:0] d_t  [6] = '{32'h01020304, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hFF000000, 32'h0};
        logic [3:0]  be_t [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h8, 4'hF};
        int i = 0;
        int got = 0;
        int last_acc = -1;
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_write = w_t[0]; b_req_addr = a_t[0];
        b_req_wdata = d_t[0]; b_req_be = be_t[0];
        for (int n = 0; n < 60 && got < 6; n++) begin
            @(negedge clk);
            if (b_resp_valid) begin
                exp_t e;
                tests++;
                if (exp0_q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_unexpected: got rdata=%h err=%b, required no response", b_resp_rdata, b_resp_err);
                end else begin
                    e = exp0_q.pop_front();
                    if (b_resp_rdata !== e.rdata || b_resp_err !== e.err || cyc != last_acc + 1 || b_req_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b_resp_%0d: got rdata=%h err=%b lat=%0d rdy=%b, required rdata=%h err=%b lat=1 rdy=0",
                                 got, b_resp_rdata, b_resp_err, cyc - last_acc, b_req_ready, e.rdata, e.err);
                    end
                end
                got++;
            end
            if (b_req_ready && b_req_valid) begin
                if (last_acc >= 0) begin
                    tests++;
                    if (cyc != last_acc + 2) begin
                        fails++;
                        $display("FAIL b2b_spacing_%0d: got %0d cycles, required 2", i, cyc - last_acc);
                    end
                end
                push_exp(1'b1, w_t[i], a_t[i], d_t[i], be_t[i]);
                last_acc = cyc;
                i++;
                @(posedge clk); #1;
                if (i < 6) begin
                    b_req_write = w_t[i]; b_req_addr = a_t[i]; b_req_wdata = d_t[i]; b_req_be = be_t[i];
                end else begin
                    b_req_valid = 1'b0;
                end
            end
        end
        tests++;
        if (got != 6) begin
            fails++;
            $display("FAIL b2b_count: got %0d responses, required 6", got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_after_store();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0 || exp0_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", exp_q.size(), exp0_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
